// File: rtl/cellnet_src_arbiter.sv
// cellnet_src_arbiter
//   Round-robin arbiter that lets four sources share one four-phase request/acknowledge
//   bus towards the sinks. A granted source's address and data are latched and driven on
//   the bus. The block runs the handshake o_req up, wait i_ack up, o_req down, wait i_ack
//   down. It then acknowledges the source and waits for that source to drop its request.
//
// Ports
//   i_clk       clock, rising edge
//   i_rst       synchronous active-high reset
//   i_src_req   per-source request (bit n = source n)
//   i_src_addr  source n address at [n*ASZ +: ASZ]
//   i_src_dat   source n data at [n*DSZ +: DSZ]
//   o_src_ack   per-source acknowledge (at most one bit high)
//   o_addr      shared-bus address
//   o_dat       shared-bus data
//   o_req       shared-bus request
//   i_ack       OR of all sink acknowledges
//   o_busy      high whenever a transfer is in progress
//   o_err       sticky timeout flag
//
// Build option
//   CELLNET_ARB_TIMEOUT_EN  when defined, each wait on i_ack is bounded by TIMEOUT cycles.
//   A timed-out transfer is abandoned without a source acknowledge, and o_err is set until
//   reset. When undefined, waits are unbounded and o_err stays 0.

`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 8
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 8
`endif

module cellnet_src_arbiter #(
  parameter int unsigned ASZ     = `ADDRESS_SIZE,
  parameter int unsigned DSZ     = `DATA_SIZE,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [3:0]       i_src_req,
  input  logic [4*ASZ-1:0] i_src_addr,
  input  logic [4*DSZ-1:0] i_src_dat,
  output logic [3:0]       o_src_ack,
  output logic [ASZ-1:0]   o_addr,
  output logic [DSZ-1:0]   o_dat,
  output logic             o_req,
  input  logic             i_ack,
  output logic             o_busy,
  output logic             o_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ_HI = 2'd1;
  localparam logic [1:0] S_REQ_LO = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]     r_state;
  logic [1:0]     r_ptr;   // last granted source
  logic [1:0]     r_gnt;   // source owning the current transfer
  logic [ASZ-1:0] r_addr;
  logic [DSZ-1:0] r_dat;
  logic           r_req;
  logic [3:0]     r_src_ack;
  logic           r_busy;
  logic           r_err;

  logic           w_any;
  logic [1:0]     w_pick;
  logic [1:0]     w_idx;
  logic           w_tmo;

  // Scan from the farthest candidate back to the nearest so the first source after r_ptr
  // is the last one written and therefore wins.
  always_comb begin
    w_any  = |i_src_req;
    w_pick = r_ptr;
    w_idx  = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k + 1);
      if (i_src_req[w_idx]) begin
        w_pick = w_idx;
      end
    end
  end

`ifdef CELLNET_ARB_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  // The count is the number of wait cycles already spent in the current phase.
  assign w_tmo = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if ((r_state == S_IDLE && w_any) || (r_state == S_REQ_HI && i_ack)) begin
      r_cnt <= '0;
    end else if (r_state == S_REQ_HI || r_state == S_REQ_LO) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
`else
  logic w_unused_timeout;

  assign w_tmo            = 1'b0;
  assign w_unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= 2'd3;
      r_gnt     <= 2'd0;
      r_addr    <= '0;
      r_dat     <= '0;
      r_req     <= 1'b0;
      r_src_ack <= 4'd0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_pick;
            r_addr  <= i_src_addr[w_pick*ASZ +: ASZ];
            r_dat   <= i_src_dat[w_pick*DSZ +: DSZ];
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_REQ_HI;
          end
        end
        S_REQ_HI: begin
          if (i_ack) begin
            r_req   <= 1'b0;
            r_state <= S_REQ_LO;
          end else if (w_tmo) begin
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            r_ptr   <= r_gnt;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_REQ_LO: begin
          if (!i_ack) begin
            r_src_ack <= 4'd1 << r_gnt;
            r_state   <= S_DONE;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_ptr   <= r_gnt;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin // S_DONE
          if (!i_src_req[r_gnt]) begin
            r_src_ack <= 4'd0;
            r_ptr     <= r_gnt;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign o_src_ack = r_src_ack;
  assign o_addr    = r_addr;
  assign o_dat     = r_dat;
  assign o_req     = r_req;
  assign o_busy    = r_busy;
  assign o_err     = r_err;

endmodule

// File: tb/tb_cellnet_src_arbiter.sv
// Self-checking bench for cellnet_src_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_cellnet_src_arbiter;

  localparam int ASZ = 8;
  localparam int DSZ = 8;
  localparam int TMO = 8;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic [3:0]       i_src_req;
  logic [4*ASZ-1:0] i_src_addr;
  logic [4*DSZ-1:0] i_src_dat;
  logic [3:0]       o_src_ack;
  logic [ASZ-1:0]   o_addr;
  logic [DSZ-1:0]   o_dat;
  logic             o_req;
  logic             i_ack;
  logic             o_busy;
  logic             o_err;

  cellnet_src_arbiter #(
    .ASZ     (ASZ),
    .DSZ     (DSZ),
    .TIMEOUT (TMO)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_src_req  (i_src_req),
    .i_src_addr (i_src_addr),
    .i_src_dat  (i_src_dat),
    .o_src_ack  (o_src_ack),
    .o_addr     (o_addr),
    .o_dat      (o_dat),
    .o_req      (o_req),
    .i_ack      (i_ack),
    .o_busy     (o_busy),
    .o_err      (o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Reference model: where the current transfer stands, in terms of the bus handshake.
  bit             m_active  = 0;  // a transfer is in progress
  bit             m_seen_hi = 0;  // sink has raised its ack
  bit             m_src_ok  = 0;  // source has been acknowledged
  int             m_last    = 3;  // last granted source
  int             m_owner   = 0;
  int             m_spent   = 0;  // wait cycles spent in the current handshake phase
  logic           m_req     = 0;
  logic [3:0]     m_ack     = 0;
  logic [ASZ-1:0] m_addr    = 0;
  logic [DSZ-1:0] m_dat     = 0;
  logic           m_err     = 0;

  bit auto_sink = 0;
  int src_mode  = 0;  // 0 manual, 1 drop request on ack, 2 random traffic
  int s_dly     = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_give_up();
    m_req    = 0;
    m_err    = 1;
    m_last   = m_owner;
    m_active = 0;
  endtask

  task automatic model_wait();
`ifdef CELLNET_ARB_TIMEOUT_EN
    m_spent++;
    if (m_spent >= TMO) model_give_up();
`endif
  endtask

  // Advance the model by one clock edge using the inputs the DUT is about to sample.
  task automatic model_step();
    if (i_rst) begin
      m_active = 0; m_req = 0; m_ack = 0; m_addr = 0; m_dat = 0; m_err = 0; m_last = 3;
    end else if (!m_active) begin
      if (i_src_req != 4'd0) begin
        for (int k = 1; k <= 4; k++) begin
          if (i_src_req[(m_last + k) % 4]) begin
            m_owner = (m_last + k) % 4;
            break;
          end
        end
        m_addr    = i_src_addr[m_owner*ASZ +: ASZ];
        m_dat     = i_src_dat[m_owner*DSZ +: DSZ];
        m_req     = 1;
        m_active  = 1;
        m_seen_hi = 0;
        m_src_ok  = 0;
        m_spent   = 0;
      end
    end else if (!m_seen_hi) begin
      if (i_ack) begin
        m_req     = 0;
        m_seen_hi = 1;
        m_spent   = 0;
      end else begin
        model_wait();
      end
    end else if (!m_src_ok) begin
      if (!i_ack) begin
        m_ack[m_owner] = 1'b1;
        m_src_ok       = 1;
      end else begin
        model_wait();
      end
    end else if (!i_src_req[m_owner]) begin
      m_ack    = 0;
      m_last   = m_owner;
      m_active = 0;
    end
  endtask

  task automatic compare();
    chk("req", o_req, m_req);
    chk("addr", o_addr, m_addr);
    chk("dat", o_dat, m_dat);
    chk("src_ack", o_src_ack, m_ack);
    chk("busy", o_busy, m_active);
    chk("err", o_err, m_err);
    chk("ack_onehot", $countones(o_src_ack) <= 1, 1);
  endtask

  task automatic sink_drive();
    if (o_req && !i_ack) begin
      if (s_dly == 0) begin i_ack = 1; s_dly = $urandom_range(0, 3); end
      else s_dly--;
    end else if (!o_req && i_ack) begin
      if (s_dly == 0) begin i_ack = 0; s_dly = $urandom_range(0, 3); end
      else s_dly--;
    end
  endtask

  task automatic src_drive();
    for (int n = 0; n < 4; n++) begin
      if (i_src_req[n]) begin
        if (o_src_ack[n]) i_src_req[n] = 1'b0;
        else if (src_mode == 2 && $urandom_range(0, 15) == 0) begin
          i_src_addr[n*ASZ +: ASZ] = ASZ'($urandom);
          i_src_dat[n*DSZ +: DSZ]  = DSZ'($urandom);
        end else if (src_mode == 2 && $urandom_range(0, 31) == 0) i_src_req[n] = 1'b0;
      end else if (src_mode == 2 && $urandom_range(0, 3) == 0) begin
        i_src_req[n]             = 1'b1;
        i_src_addr[n*ASZ +: ASZ] = ASZ'($urandom);
        i_src_dat[n*DSZ +: DSZ]  = DSZ'($urandom);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge i_clk);
    @(negedge i_clk);
    cyc++;
    compare();
    if (auto_sink) sink_drive();
    if (src_mode != 0) src_drive();
  endtask

  task automatic do_reset();
    auto_sink = 0; src_mode = 0;
    i_rst = 1; i_ack = 0; i_src_req = 0; i_src_addr = 0; i_src_dat = 0;
    tick();
    i_rst = 0;
  endtask

  task automatic set_src(input int n, input int a, input int d);
    i_src_addr[n*ASZ +: ASZ] = ASZ'(a);
    i_src_dat[n*DSZ +: DSZ]  = DSZ'(d);
  endtask

  initial begin
    int ng;
    int gcyc[$];
    logic [DSZ-1:0] gdat[$];
    bit prev_req;
    int budget;

    i_rst = 1; i_ack = 0; i_src_req = 0; i_src_addr = 0; i_src_dat = 0;
    tick();
    tick();
    chk("rst_req", o_req, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ack", o_src_ack, 0);

    // Single transfer from source 0, sink acks one cycle after o_req.
    do_reset();
    set_src(0, 1, 5); i_src_req = 4'b0001;
    tick();
    chk("a_req", o_req, 1); chk("a_addr", o_addr, 1); chk("a_dat", o_dat, 5);
    chk("a_busy", o_busy, 1);
    i_ack = 1; tick();
    chk("a_req_low", o_req, 0); chk("a_no_ack_yet", o_src_ack, 0);
    i_ack = 0; tick();
    chk("a_src_ack", o_src_ack, 4'b0001); chk("a_busy_done", o_busy, 1);
    i_src_req = 0; tick();
    chk("a_ack_clr", o_src_ack, 0); chk("a_busy_clr", o_busy, 0);

    // All four sources request; grant order follows data n+1.
    do_reset();
    for (int n = 0; n < 4; n++) set_src(n, n, n + 1);
    i_src_req = 4'hf; auto_sink = 1; src_mode = 1; s_dly = 0;
    ng = 0; prev_req = 0; budget = 200;
    while (ng < 4 && budget > 0) begin
      tick();
      budget--;
      if (o_req && !prev_req) begin gdat.push_back(o_dat); gcyc.push_back(cyc); ng++; end
      prev_req = o_req;
    end
    chk("b_ngrants", ng, 4);
    for (int i = 0; i < ng; i++) chk("b_order", gdat[i], i + 1);
    for (int i = 1; i < ng; i++) chk("b_gap_ge4", (gcyc[i] - gcyc[i-1]) >= 4, 1);
    budget = 50;
    while (o_busy && budget > 0) begin tick(); budget--; end
    chk("b_drain", o_busy, 0);

    // Source data change during the transfer does not reach the bus.
    do_reset();
    set_src(2, 2, 7); i_src_req = 4'b0100;
    tick(); chk("c_dat_grant", o_dat, 7);
    set_src(2, 2, 9); tick(); chk("c_dat_hi", o_dat, 7);
    i_ack = 1; tick(); chk("c_dat_lo", o_dat, 7);
    i_ack = 0; tick(); chk("c_dat_done", o_dat, 7); chk("c_src_ack", o_src_ack, 4'b0100);
    i_src_req = 0; tick(); chk("c_dat_hold", o_dat, 7); chk("c_idle", o_busy, 0);

    // Reset while waiting for the sink to release ack aborts the transfer.
    do_reset();
    set_src(1, 3, 4); i_src_req = 4'b0010;
    tick(); i_ack = 1; tick();
    chk("d_in_lo", o_req, 0);
    i_rst = 1; tick();
    chk("d_rst_req", o_req, 0); chk("d_rst_addr", o_addr, 0); chk("d_rst_dat", o_dat, 0);
    chk("d_rst_ack", o_src_ack, 0); chk("d_rst_busy", o_busy, 0); chk("d_rst_err", o_err, 0);
    i_rst = 0; i_ack = 0; tick();
    chk("d_rearb_req", o_req, 1); chk("d_rearb_addr", o_addr, 3);
    i_ack = 1; tick(); i_ack = 0; tick();
    chk("d_src_ack", o_src_ack, 4'b0010);
    i_src_req = 0; tick();

    // Sources 1 and 3: after 1 is served, 3 goes before a re-asserted 1.
    do_reset();
    set_src(1, 1, 11); set_src(3, 3, 33); i_src_req = 4'b1010;
    tick(); chk("e_first", o_addr, 1);
    i_ack = 1; tick(); i_ack = 0; tick();
    chk("e_ack1", o_src_ack, 4'b0010);
    i_src_req = 4'b1000; tick();
    i_src_req = 4'b1010; tick();
    chk("e_second", o_addr, 3);
    i_ack = 1; tick(); i_ack = 0; tick();
    chk("e_ack3", o_src_ack, 4'b1000);
    i_src_req = 4'b0010; tick(); tick();
    chk("e_third", o_addr, 1);
    i_ack = 1; tick(); i_ack = 0; tick(); i_src_req = 0; tick();

`ifdef CELLNET_ARB_TIMEOUT_EN
    // Sink never answers: transfer is abandoned after TMO wait cycles.
    do_reset();
    set_src(0, 5, 50); set_src(1, 6, 60); i_src_req = 4'b0001;
    tick(); chk("f_req", o_req, 1);
    repeat (TMO - 1) tick();
    chk("f_err_early", o_err, 0); chk("f_req_held", o_req, 1);
    tick();
    chk("f_err", o_err, 1); chk("f_req_drop", o_req, 0); chk("f_idle", o_busy, 0);
    chk("f_no_ack", o_src_ack, 0);
    i_src_req = 4'b0011; tick();
    chk("f_next", o_addr, 6); chk("f_next_req", o_req, 1); chk("f_err_sticky", o_err, 1);
    i_ack = 1; tick(); i_ack = 0; tick(); i_src_req = 0; tick();
`endif

    // Randomized traffic with occasional resets.
    do_reset();
    auto_sink = 1; src_mode = 2; s_dly = 0;
    repeat (3000) begin
      i_rst = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
